// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : State, opcode and control-word definitions for the multicycle
//             MIPS main controller.
//  Revision : 1.0
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_output_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_output_decode
//  Purpose  : Moore output decode, state -> control word (pure combinational).
//  Revision : 1.0
// ============================================================================
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.alusrcb = 2'b01;
                ctrl_o.irwrite = 1'b1;
                ctrl_o.pcwrite = 1'b1;
            end
            S_DECODE:  ctrl_o.alusrcb = 2'b11;
            S_MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b10;
            end
            S_MEMRD:   ctrl_o.iord = 1'b1;
            S_MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = 2'b01;
                ctrl_o.branch  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b10;
            end
            S_ADDIWB:  ctrl_o.regwrite = 1'b1;
            S_JEX: begin
                ctrl_o.pcsrc   = 2'b10;
                ctrl_o.pcwrite = 1'b1;
            end
            default:   ctrl_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Multicycle MIPS main controller: state sequencing, retire and
//             illegal-opcode tracking, pcen and reset gating of write enables.
//  Revision : 1.0
// ============================================================================
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  op,
    input  logic            zero,
    output logic [1:0]      aluop,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic            iord,
    output logic            regdst,
    output logic            memtoreg,
    output logic            irwrite,
    output logic            memwrite,
    output logic            regwrite,
    output logic            pcen,
    output logic [3:0]      state,
    output logic            illegal_op,
    output logic [CNTW-1:0] retired
);

    state_t          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic            retire_d;
    logic [CNTW-1:0] retired_q;
    ctrl_t           ctrl;

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        retire_d  = 1'b0;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                if (op == OPW'(OP_LW) || op == OPW'(OP_SW)) state_d = S_MEMADR;
                else if (op == OPW'(OP_RTYPE))              state_d = S_EXECUTE;
                else if (op == OPW'(OP_BEQ))                state_d = S_BEQ;
                else if (op == OPW'(OP_ADDI))               state_d = S_ADDIEX;
                else if (op == OPW'(OP_J))                  state_d = S_JEX;
                else                                        illegal_d = 1'b1;
            end
            S_MEMADR:  state_d = (op == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_ADDIWB, S_JEX: retire_d = 1'b1;
            default:   state_d = S_FETCH;
        endcase
    end

    // Reset mid-instruction drops the instruction without retiring it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (retire_d) retired_q <= retired_q + CNTW'(1);
        end
    end

    mc_output_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    assign aluop      = ctrl.aluop;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign pcsrc      = ctrl.pcsrc;
    assign iord       = ctrl.iord;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign irwrite    = ctrl.irwrite  & ~reset;
    assign memwrite   = ctrl.memwrite & ~reset;
    assign regwrite   = ctrl.regwrite & ~reset;
    assign pcen       = (ctrl.pcwrite | (ctrl.branch & zero)) & ~reset;
    assign state      = state_q;
    assign illegal_op = illegal_q;
    assign retired    = retired_q;

endmodule
`default_nettype wire
